// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
//   Handshake and operand/result bundle for serial_subtractor.
//   master : requester side (drives start/a/b, observes busy/done/d/bout)
//   slave  : the subtractor itself
//   Optional macro SERIAL_SUBTRACTOR_SIGNED_OVF_EN adds the ovf result bit.
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    logic             ovf;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  d,
        input  bout,
        input  ovf
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output d,
        output bout,
        output ovf
    );
`else
    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  d,
        input  bout
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output d,
        output bout
    );
`endif

endinterface : serial_subtractor_if

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, d = a - b, LSB first, one bit per clock.
//   A single full-subtractor cell plus a borrow flop walk the operands.
//
//   Handshake: start is taken only in IDLE; busy is high for WIDTH cycles;
//   done pulses for one cycle, at which point d/bout (and ovf) are loaded.
//   d/bout hold their value until the next done.
//
//   Optional macro SERIAL_SUBTRACTOR_SIGNED_OVF_EN adds a signed two's-
//   complement overflow flag (ovf) loaded alongside d.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    // Counter only needs to reach WIDTH-1 (index of the last processed bit).
    localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Full-subtractor cell: returns {borrow_out, difference}.
    // -------------------------------------------------------------------------
    function automatic logic [1:0] sub_cell(
        input logic x,
        input logic y,
        input logic br
    );
        logic diff;
        logic bnext;
        diff  = x ^ y ^ br;
        bnext = (~x & y) | (~(x ^ y) & br);
        return {bnext, diff};
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    logic             r_ovf;
    logic             w_ovf;
`endif

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    state_t           w_next_state;
    logic             w_accept;
    logic             w_last;
    logic [1:0]       w_cell;
    logic             w_diff;
    logic             w_borrow_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    // Next-state decode and the accept/last-bit strobes used by the datapath.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = ST_RUN;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST_BIT) begin
                    w_next_state = ST_DONE;
                    w_last       = 1'b1;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                // done is a single-cycle pulse; start is ignored here.
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Subtractor cell on the current LSBs and the running borrow.
    always_comb begin
        w_cell       = sub_cell(r_a[0], r_b[0], r_borrow);
        w_diff       = w_cell[0];
        w_borrow_nxt = w_cell[1];
        // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        w_res_nxt    = {w_diff, r_res[WIDTH-1:1]};
    end

`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    // On the last bit the cell sees the operand MSBs and produces d's MSB,
    // so signed overflow falls out without keeping copies of the operands.
    always_comb begin
        w_ovf = (r_a[0] ^ r_b[0]) & (w_diff ^ r_a[0]);
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand shift registers, borrow flop and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_res    <= {WIDTH{1'b0}};
            r_borrow <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_res    <= {WIDTH{1'b0}};
            r_borrow <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
        end else if (r_state == ST_RUN) begin
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_res    <= w_res_nxt;
            r_borrow <= w_borrow_nxt;
            r_cnt    <= r_cnt + CNT_ONE;
        end else begin
            r_a      <= r_a;
            r_b      <= r_b;
            r_res    <= r_res;
            r_borrow <= r_borrow;
            r_cnt    <= r_cnt;
        end
    end

    // Registered handshake outputs: busy over the WIDTH run cycles, done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (w_last) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
        end else if (r_state == ST_RUN) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end
    end

    // Result registers: loaded only on the last bit, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d    <= {WIDTH{1'b0}};
            r_bout <= 1'b0;
        end else if (w_last) begin
            r_d    <= w_res_nxt;
            r_bout <= w_borrow_nxt;
        end else begin
            r_d    <= r_d;
            r_bout <= r_bout;
        end
    end

`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    // Overflow flag, loaded together with d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_ovf;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign bus.ovf  = r_ovf;
`endif

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.d    = r_d;
    assign bus.bout = r_bout;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed self-checking bench for serial_subtractor (WIDTH=8).
//   Inputs change and outputs are sampled on the falling clock edge.
//   Overflow vectors run only when SERIAL_SUBTRACTOR_SIGNED_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next done pulse, sampled on falling edges.
    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 3 * W && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    // One full operation with latency/busy-length checks; operands are
    // scrambled right after capture to prove they are not re-sampled.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb);
        int n_busy;
        int lat;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        n_busy = 0;
        lat    = 0;
        seen   = 1'b0;
        for (int i = 1; i <= 3 * W && !seen; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end else if (bus.busy === 1'b1) begin
                n_busy++;
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(W + 1));
        check({tag, " busy_cycles"}, 32'(n_busy), 32'(W));
        check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, " d"}, 32'(bus.d), 32'(ed));
        check({tag, " bout"}, 32'(bus.bout), 32'(eb));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, " d_held"}, 32'(bus.d), 32'(ed));
    endtask

    initial begin
        bit seen;
        int pulses;
        int t1;
        int t2;
        logic [W-1:0] d_at_done;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset, then 20 idle cycles with no start.
        repeat (2) @(negedge clk);
        check("reset outputs", {22'd0, bus.busy, bus.done, bus.d, bus.bout}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle outputs", {22'd0, bus.busy, bus.done, bus.d, bus.bout}, 32'd0);
        end

        // Basic subtraction and borrow cases.
        run_op("200-55", 8'd200, 8'd55, 8'd145, 1'b0);
        run_op("5-10", 8'd5, 8'd10, 8'hFB, 1'b1);
        run_op("0-1", 8'h00, 8'h01, 8'hFF, 1'b1);
        run_op("A5-A5", 8'hA5, 8'hA5, 8'h00, 1'b0);
        run_op("0-0", 8'h00, 8'h00, 8'h00, 1'b0);
        run_op("200-55 again", 8'd200, 8'd55, 8'd145, 1'b0);

        // Result holds between operations while inputs wander.
        bus.a = 8'h3C;
        bus.b = 8'hC3;
        repeat (5) @(negedge clk);
        check("hold d", 32'(bus.d), 32'd145);
        check("hold bout", 32'(bus.bout), 32'd0);

        // start during busy is ignored: one done, result of the first operands.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'd1;
        bus.b     = 8'd1;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        pulses    = 0;
        d_at_done = '0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                pulses++;
                d_at_done = bus.d;
            end
        end
        check("busy-start pulses", 32'(pulses), 32'd1);
        check("busy-start d", 32'(d_at_done), 32'd6);
        check("busy-start bout", 32'(bus.bout), 32'd0);

        // Back-to-back with start held: one result every W+2 cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd20;
        bus.b     = 8'd3;
        wait_done(seen);
        check("b2b first done", 32'(seen), 32'd1);
        t1 = cyc;
        wait_done(seen);
        bus.start = 1'b0;
        check("b2b second done", 32'(seen), 32'd1);
        t2 = cyc;
        check("b2b period", 32'(t2 - t1), 32'(W + 2));
        check("b2b d", 32'(bus.d), 32'd17);
        repeat (3) @(negedge clk);

        // Reset mid-operation aborts: outputs clear at once, no done follows.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd100;
        bus.b     = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid busy before rst", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid rst outputs", {22'd0, bus.busy, bus.done, bus.d, bus.bout}, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        check("no activity after abort", 32'(pulses), 32'd0);
        run_op("7-2", 8'd7, 8'd2, 8'd5, 1'b0);

`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
        // Signed overflow flag.
        run_op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0);
        check("80-01 ovf", 32'(bus.ovf), 32'd1);
        run_op("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1);
        check("7F-FF ovf", 32'(bus.ovf), 32'd1);
        run_op("10-01", 8'h10, 8'h01, 8'h0F, 1'b0);
        check("10-01 ovf", 32'(bus.ovf), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net: every wait above is bounded, this only guards against a stall.
    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_subtractor
